// File: rtl/mult8_sequencer_pkg.sv
// Shared definitions for the nibble-serial 8x8 multiplier: FSM states, step count
// and the per-step shift applied to each 4x4 partial product.
package mult8_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NSTEPS = 4;

  // Partial product weights: lo*lo, hi*lo, lo*hi, hi*hi.
  function automatic logic [3:0] step_shift(input logic [1:0] step);
    case (step)
      2'd0:    step_shift = 4'd0;
      2'd1:    step_shift = 4'd4;
      2'd2:    step_shift = 4'd4;
      default: step_shift = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/mult8_sequencer_multiplier.sv
// Combinational 4x4 unsigned array multiplier shared by all four sequencer steps.
module multiplier (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] p
);

  always_comb begin
    // NOTE: blocking assignments here, because p is accumulated row by row within a
    // single combinational evaluation; registered state elsewhere uses <=.
    p = 8'd0;
    for (int i = 0; i < 4; i++) begin
      if (y[i]) p = p + ({4'd0, x} << i);
    end
  end

endmodule

// File: rtl/mult8_sequencer.sv
// 8x8 unsigned multiplier built by stepping one 4x4 multiplier over four nibble
// pairs, with a start/busy/done handshake and a held product register.
module mult8_sequencer
  import mult8_sequencer_pkg::*;
#(
  parameter bit SKIP_ZERO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        clr,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);

  state_t      state_q, state_d;
  logic [1:0]  step_q;
  logic [7:0]  a_r, b_r;
  logic [15:0] acc;
  logic [3:0]  nib_a, nib_b;
  logic [7:0]  pp;
  logic [15:0] pp_shifted;
  logic        accept, last_step, skip_now;

  assign accept    = (state_q == IDLE) && start && !clr;
  assign last_step = (step_q == 2'(NSTEPS - 1));
  // Operands are already latched, so checking them in step 0 reflects the start values.
  assign skip_now  = SKIP_ZERO && (step_q == 2'd0) && ((a_r == 8'd0) || (b_r == 8'd0));
  assign busy      = (state_q != IDLE);

  assign nib_a      = step_q[0] ? a_r[7:4] : a_r[3:0];
  assign nib_b      = step_q[1] ? b_r[7:4] : b_r[3:0];
  assign pp_shifted = 16'(pp) << step_shift(step_q);

  multiplier u_multiplier (
    .x (nib_a),
    .y (nib_b),
    .p (pp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: default assigned first so every path drives state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = MUL;
      MUL: begin
        if (clr)                        state_d = IDLE;
        else if (skip_now || last_step) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: operand and accumulator registers are reset too; it costs little and keeps
      // the datapath free of X values before the first start.
      step_q  <= 2'd0;
      a_r     <= 8'd0;
      b_r     <= 8'd0;
      acc     <= 16'd0;
      product <= 16'd0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_r    <= a;
            b_r    <= b;
            acc    <= 16'd0;
            step_q <= 2'd0;
          end
        end
        MUL: begin
          if (!clr) begin
            if (skip_now) begin
              product <= 16'd0;
              done    <= 1'b1;
            end else if (last_step) begin
              product <= acc + pp_shifted;
              done    <= 1'b1;
            end else begin
              acc    <= acc + pp_shifted;
              step_q <= step_q + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult8_sequencer.sv
// Bench for mult8_sequencer: one instance without and one with zero-skip, both checked
// every cycle against a cycle-count model plus directed literal cases.
module tb_mult8_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        clr = 1'b0;
  logic [7:0]  a = 8'd0;
  logic [7:0]  b = 8'd0;
  logic        busy0, done0, busy1, done1;
  logic [15:0] prod0, prod1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mult8_sequencer #(.SKIP_ZERO(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .clr(clr), .a(a), .b(b),
    .busy(busy0), .done(done0), .product(prod0)
  );

  mult8_sequencer #(.SKIP_ZERO(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .clr(clr), .a(a), .b(b),
    .busy(busy1), .done(done1), .product(prod1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted operation keeps busy high for a fixed number of cycles
  // (5, or 2 when zero-skip applies); the last of them is the done cycle, where the
  // product a*b becomes visible. clr ends the operation with no further effect.
  int          rem[2]    = '{0, 0};
  logic [15:0] m_prod[2] = '{16'd0, 16'd0};
  logic [15:0] pend[2]   = '{16'd0, 16'd0};
  logic        m_done[2] = '{1'b0, 1'b0};

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        rem[k]    = 0;
        m_prod[k] = 16'd0;
        m_done[k] = 1'b0;
      end else begin
        m_done[k] = 1'b0;
        if (rem[k] > 0) begin
          if (clr) rem[k] = 0;
          else begin
            rem[k]--;
            if (rem[k] == 1) begin
              m_done[k] = 1'b1;
              m_prod[k] = pend[k];
            end
          end
        end else if (start && !clr) begin
          pend[k] = 16'(a) * 16'(b);
          rem[k]  = (k == 1 && (a == 8'd0 || b == 8'd0)) ? 2 : 5;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("busy0", 32'(busy0), 32'(rem[0] > 0));
    check("done0", 32'(done0), 32'(m_done[0]));
    check("prod0", 32'(prod0), 32'(m_prod[0]));
    check("busy1", 32'(busy1), 32'(rem[1] > 0));
    check("done1", 32'(done1), 32'(m_done[1]));
    check("prod1", 32'(prod1), 32'(m_prod[1]));
  end

  // Observes n cycles starting at the current negedge; latency counts from the
  // cycle right after the start edge (index 0).
  task automatic run_window(input int n, output int lat0, output int lat1,
                            output int nd0, output int nd1, output int bc0, output int bc1);
    lat0 = -1; lat1 = -1; nd0 = 0; nd1 = 0; bc0 = 0; bc1 = 0;
    for (int i = 0; i < n; i++) begin
      if (done0) begin nd0++; if (lat0 < 0) lat0 = i; end
      if (done1) begin nd1++; if (lat1 < 0) lat1 = i; end
      if (busy0) bc0++;
      if (busy1) bc1++;
      @(negedge clk);
    end
  endtask

  task automatic do_op(input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp_p,
                       input int exp_l0, input int exp_l1);
    int l0, l1, n0, n1, b0, b1;
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_window(12, l0, l1, n0, n1, b0, b1);
    check("lat0", 32'(l0), 32'(exp_l0));
    check("lat1", 32'(l1), 32'(exp_l1));
    check("ndone0", 32'(n0), 32'd1);
    check("ndone1", 32'(n1), 32'd1);
    check("busycyc0", 32'(b0), 32'(exp_l0 + 1));
    check("busycyc1", 32'(b1), 32'(exp_l1 + 1));
    check("litprod0", 32'(prod0), 32'(exp_p));
    check("litprod1", 32'(prod1), 32'(exp_p));
  endtask

  initial begin
    int l0, l1, n0, n1, b0, b1;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_prod", 32'(prod0), 32'd0);
    rst = 1'b0;

    do_op(8'd10, 8'd12, 16'h0078, 4, 4);
    do_op(8'hD5, 8'hC3, 16'hA23F, 4, 4);
    do_op(8'hFF, 8'hFF, 16'hFE01, 4, 4);
    do_op(8'h00, 8'h5A, 16'h0000, 4, 1);
    do_op(8'h5A, 8'h00, 16'h0000, 4, 1);

    // Start while busy is ignored.
    @(negedge clk);
    a = 8'h10; b = 8'h10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_window(12, l0, l1, n0, n1, b0, b1);
    check("ovl_ndone", 32'(n0), 32'd1);
    check("ovl_prod", 32'(prod0), 32'h0100);

    // Abort at step 2 keeps the previous product.
    do_op(8'h0F, 8'h0F, 16'h00E1, 4, 4);
    @(negedge clk);
    a = 8'h22; b = 8'h33; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_busy", 32'(busy0), 32'd0);
    run_window(10, l0, l1, n0, n1, b0, b1);
    check("clr_ndone", 32'(n0), 32'd0);
    check("clr_prod", 32'(prod0), 32'h00E1);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    a = 8'h37; b = 8'h59; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy0), 32'd0);
    check("arst_done", 32'(done0), 32'd0);
    check("arst_prod", 32'(prod0), 32'd0);
    check("arst_busy1", 32'(busy1), 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    do_op(8'h37, 8'h59, 16'h131F, 4, 4);

    // Randomized traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      start = ($urandom_range(2) == 0);
      clr   = ($urandom_range(15) == 0);
      a     = ($urandom_range(7) == 0) ? 8'd0 : 8'($urandom);
      b     = ($urandom_range(7) == 0) ? 8'd0 : 8'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    clr   = 1'b0;
    repeat (8) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
